// File: rtl/vga_frame_sequencer.sv
// vga_frame_sequencer: steps through the 640x480 encrypted pass and then the
// 320x240 decrypted pass. It also shares the single frame-memory port between
// display fetches, which always win, and a valid/ready image writer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start, memory port serves the writer only
// PASS640  | showing the 640x480 buffer, counting frames
// PASS320  | showing the 320x240 buffer, counting frames
// FINISHED | sequence complete, done held until the next start
module vga_frame_sequencer #(
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 24,
    parameter int BASE640   = 0,
    parameter int BASE320   = 307200,
    parameter int WORDS640  = 307200,
    parameter int WORDS320  = 76800,
    parameter int FRAMES640 = 1,
    parameter int FRAMES320 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              frame_end,
    input  logic              pix_req,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              pix_rvalid,
    output logic              pix_black,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mode,
    output logic              busy,
    output logic              done640,
    output logic              done
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PASS640  = 2'd1;
    localparam logic [1:0] S_PASS320  = 2'd2;
    localparam logic [1:0] S_FINISHED = 2'd3;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST640 = CNT_W'(FRAMES640 - 1);
    localparam logic [CNT_W-1:0] LAST320 = CNT_W'(FRAMES320 - 1);

    localparam logic [ADDR_W-1:0] BASE640_A = ADDR_W'(BASE640);
    localparam logic [ADDR_W-1:0] BASE320_A = ADDR_W'(BASE320);
    localparam logic [ADDR_W:0]   WORDS640_A = (ADDR_W+1)'(WORDS640);
    localparam logic [ADDR_W:0]   WORDS320_A = (ADDR_W+1)'(WORDS320);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done640_q, done640_d;
    logic             done_q, done_d;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              rd_pend_q, black_pend_q;
    logic              pix_rvalid_q, pix_black_q;

    logic              fetch;
    logic              in_range;
    logic [ADDR_W-1:0] base_cur;
    logic [ADDR_W:0]   words_cur;

    assign busy     = (state_q == S_PASS640) || (state_q == S_PASS320);
    assign mode     = (state_q == S_PASS320) || (state_q == S_FINISHED);
    assign wr_ready = !(pix_req && busy);
    assign fetch    = pix_req && busy;

    // Base and size follow the pass currently shown; a terminating frame_end
    // does not affect a fetch issued in the same cycle.
    assign base_cur  = (state_q == S_PASS320) ? BASE320_A : BASE640_A;
    assign words_cur = (state_q == S_PASS320) ? WORDS320_A : WORDS640_A;
    assign in_range  = {1'b0, pix_addr} < words_cur;

    assign done640    = done640_q;
    assign done       = done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign pix_rvalid = pix_rvalid_q;
    assign pix_black  = pix_black_q;

    // Pass sequencing and frame counting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done640_d = done640_q;
        done_d    = done_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PASS640;
                    cnt_d   = '0;
                end
            end
            S_PASS640: begin
                if (frame_end) begin
                    if (cnt_q == LAST640) begin
                        state_d   = S_PASS320;
                        cnt_d     = '0;
                        done640_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PASS320: begin
                if (frame_end) begin
                    if (cnt_q == LAST320) begin
                        state_d = S_FINISHED;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d   = S_PASS640;
                    cnt_d     = '0;
                    done640_d = 1'b0;
                    done_d    = 1'b0;
                end
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            done640_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done640_q <= done640_d;
            done_q    <= done_d;
        end
    end

    // Memory port: display fetch first, then an accepted write; the address
    // holds when the port is idle or the fetch is out of range.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if (fetch) begin
                if (in_range) begin
                    mem_addr_q <= base_cur + pix_addr;
                end
            end else if (wr_valid) begin
                mem_addr_q  <= wr_addr;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= wr_data;
            end
        end
    end

    // Two-stage fetch tag pipeline so pix_rvalid lines up with RAM read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q    <= 1'b0;
            black_pend_q <= 1'b0;
            pix_rvalid_q <= 1'b0;
            pix_black_q  <= 1'b0;
        end else begin
            rd_pend_q    <= fetch;
            black_pend_q <= fetch && !in_range;
            pix_rvalid_q <= rd_pend_q;
            pix_black_q  <= black_pend_q;
        end
    end

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Scoreboard bench for vga_frame_sequencer: a cycle model of the pass
// sequence and memory arbitration queues expected responses, and a monitor
// on the falling edge compares them with what the DUT presents.
module tb_vga_frame_sequencer;

    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 24;
    localparam int BASE640   = 0;
    localparam int BASE320   = 307200;
    localparam int WORDS640  = 307200;
    localparam int WORDS320  = 76800;
    localparam int FRAMES640 = 1;
    localparam int FRAMES320 = 1;

    logic              clk = 1'b0;
    logic              rst, start, frame_end, pix_req, wr_valid;
    logic [ADDR_W-1:0] pix_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              pix_rvalid, pix_black, wr_ready, mem_we, mode, busy, done640, done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    vga_frame_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE640(BASE640), .BASE320(BASE320),
        .WORDS640(WORDS640), .WORDS320(WORDS320),
        .FRAMES640(FRAMES640), .FRAMES320(FRAMES320)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_end(frame_end),
        .pix_req(pix_req), .pix_addr(pix_addr),
        .pix_rvalid(pix_rvalid), .pix_black(pix_black),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mode(mode), .busy(busy), .done640(done640), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit black;
    } pix_exp_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    pix_exp_t pq[$];
    wr_exp_t  wq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_en = 0;

    // Reference model: 0 idle, 1 showing 640 image, 2 showing 320 image, 3 finished
    int                phase = 0;
    int                frames = 0;
    bit                m_done640 = 0, m_done = 0;
    logic [ADDR_W-1:0] exp_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        int words, base;
        cyc++;
        if (rst) begin
            phase = 0; frames = 0; m_done640 = 0; m_done = 0; exp_addr = '0;
            pq.delete();
            wq.delete();
        end else begin
            words = (phase == 2) ? WORDS320 : WORDS640;
            base  = (phase == 2) ? BASE320 : BASE640;
            if (pix_req && (phase == 1 || phase == 2)) begin
                pq.push_back('{due: cyc + 1, black: (int'(pix_addr) >= words)});
                if (int'(pix_addr) < words)
                    exp_addr = ADDR_W'((base + int'(pix_addr)) % (1 << ADDR_W));
            end else if (wr_valid) begin
                wq.push_back('{due: cyc, data: wr_data});
                exp_addr = wr_addr;
            end
            case (phase)
                0: if (start) begin phase = 1; frames = 0; end
                1: if (frame_end) begin
                    frames++;
                    if (frames == FRAMES640) begin phase = 2; frames = 0; m_done640 = 1; end
                end
                2: if (frame_end) begin
                    frames++;
                    if (frames == FRAMES320) begin phase = 3; frames = 0; m_done = 1; end
                end
                default: if (start) begin phase = 1; frames = 0; m_done640 = 0; m_done = 0; end
            endcase
        end
        mon_en = 1;
    end

    always @(negedge clk) begin
        bit exp_rv, exp_we;
        if (mon_en) begin
            check("mode", 32'(mode), 32'(phase >= 2));
            check("busy", 32'(busy), 32'(phase == 1 || phase == 2));
            check("done640", 32'(done640), 32'(m_done640));
            check("done", 32'(done), 32'(m_done));
            check("wr_ready", 32'(wr_ready), 32'(!(pix_req && (phase == 1 || phase == 2))));
            check("mem_addr", 32'(mem_addr), 32'(exp_addr));

            while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
            exp_rv = (pq.size() > 0 && pq[0].due == cyc);
            check("pix_rvalid", 32'(pix_rvalid), 32'(exp_rv));
            if (pix_rvalid && exp_rv) begin
                check("pix_black", 32'(pix_black), 32'(pq[0].black));
                void'(pq.pop_front());
            end

            while (wq.size() > 0 && wq[0].due < cyc) void'(wq.pop_front());
            exp_we = (wq.size() > 0 && wq[0].due == cyc);
            check("mem_we", 32'(mem_we), 32'(exp_we));
            if (mem_we && exp_we) begin
                check("mem_wdata", 32'(mem_wdata), 32'(wq[0].data));
                void'(wq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; frame_end = 0; pix_req = 0; wr_valid = 0;
    endtask

    initial begin
        int sel;
        rst = 1; start = 0; frame_end = 0; pix_req = 0; wr_valid = 0;
        pix_addr = '0; wr_addr = '0; wr_data = '0;
        #1;
        step(); step(); step();
        idle_inputs(); step();

        // frame_end in IDLE is ignored
        frame_end = 1; step(); frame_end = 0; step();

        // start sequence, then a start during PASS640 that must be ignored
        start = 1; step(); start = 0; step();
        start = 1; step(); start = 0; step();

        // out-of-range and in-range fetch in PASS640
        pix_req = 1; pix_addr = 19'd307200; step();
        pix_req = 0; step(); step();
        pix_req = 1; pix_addr = 19'd5; step();
        pix_req = 0; step(); step();

        // contention: writer held while display toggles 1,1,0,1
        wr_valid = 1; wr_addr = 19'd1234; wr_data = 24'hA5C3E1;
        pix_addr = 19'd10;
        pix_req = 1; step();
        pix_req = 1; step();
        pix_req = 0; step();
        pix_req = 1; step();
        wr_valid = 0; pix_req = 0; step(); step();

        // to PASS320, fetches in and out of range
        frame_end = 1; step(); frame_end = 0; step();
        pix_req = 1; pix_addr = 19'd5; step();
        pix_addr = 19'd76800; step();
        pix_addr = 19'd76799; step();
        pix_req = 0; step(); step();

        // finish, restart, then reset together with fetch and terminating frame_end
        frame_end = 1; step(); frame_end = 0; step();
        start = 1; step(); start = 0; step();
        frame_end = 1; step(); frame_end = 0; step();
        rst = 1; pix_req = 1; pix_addr = 19'd7; frame_end = 1; step();
        idle_inputs(); step(); step(); step();

        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 29) == 0);
            frame_end = ($urandom_range(0, 39) == 0);
            pix_req   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            case (sel)
                0:       pix_addr = ADDR_W'(WORDS320 - 1 + $urandom_range(0, 1));
                1:       pix_addr = ADDR_W'(WORDS640 - 1 + $urandom_range(0, 1));
                default: pix_addr = ADDR_W'($urandom);
            endcase
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = ADDR_W'($urandom);
            wr_data  = DATA_W'($urandom);
            step();
        end

        idle_inputs();
        repeat (4) step();
        check("pix_queue_empty", 32'(pq.size()), 32'd0);
        check("wr_queue_empty", 32'(wq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_frame_sequencer.md
# vga_frame_sequencer

Controller that sits between the VGA timing/pixel pipeline and the single-port frame memory. It sequences the two display passes: the 640x480 encrypted image first, then the 320x240 decrypted image. It raises `done640` and `done` at the pass boundaries. It also arbitrates the one memory port between display pixel fetches, which have strict priority, and an image writer using a valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, 19: frame-memory address width.
- `DATA_W`, 24: pixel width (R,G,B × 8).
- `BASE640`, 0: base word address of the 640x480 encrypted buffer.
- `BASE320`, 307200: base word address of the 320x240 decrypted buffer.
- `WORDS640`, 307200: word count of the 640 pass.
- `WORDS320`, 76800: word count of the 320 pass.
- `FRAMES640`, 1: frames displayed in the 640 pass (≥1).
- `FRAMES320`, 1: frames displayed in the 320 pass (≥1).

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: pulse; begins a sequence from IDLE or FINISHED.
- `frame_end`  in  1: one-cycle pulse from VGA timing at the end of each frame.
- `pix_req`  in  1: display fetch request.
- `pix_addr`  in  ADDR_W: word address relative to the current pass buffer.
- `pix_rvalid`  out  1: fetched pixel valid on `mem_rdata` (external) this cycle.
- `pix_black`  out  1: with `pix_rvalid`, marks an out-of-range fetch; the display outputs black.
- `wr_valid`  in  1: writer has a word.
- `wr_ready`  out  1: writer accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  ADDR_W: absolute write address.
- `wr_data`  in  DATA_W: write data.
- `mem_addr`  out  ADDR_W: registered memory address.
- `mem_we`  out  1: registered write enable.
- `mem_wdata`  out  DATA_W: registered write data.
- `mode`  out  1: 0 = 640 path, 1 = 320 path.
- `busy`  out  1: high in PASS640 and PASS320.
- `done640`  out  1: sticky; the 640 pass is complete.
- `done`  out  1: sticky; the whole sequence is complete.

## Operation
- States are IDLE, PASS640, PASS320 and FINISHED. Reset enters IDLE.
- IDLE --start--> PASS640, with the frame counter cleared.
- PASS640: each `frame_end` increments the counter. When the FRAMES640-th pulse arrives, the block goes to PASS320, clears the counter and sets `done640`.
- PASS320: when the FRAMES320-th `frame_end` arrives, the block goes to FINISHED and sets `done`.
- FINISHED --start--> PASS640, clearing `done640` and `done`.
- `start` is ignored in the PASS states. `frame_end` is ignored in IDLE and FINISHED.
- `mode` is 0 in IDLE and PASS640, and 1 in PASS320 and FINISHED.
- Fetch handling in the PASS states:
  - A fetch with `pix_addr < WORDS` of the current pass drives `mem_addr = BASE + pix_addr` with `mem_we = 0`. The sum wraps modulo 2^ADDR_W.
  - A fetch with `pix_addr ≥ WORDS` issues no memory access. It still produces `pix_rvalid` with `pix_black = 1` at the same latency.
- `pix_req` outside the PASS states is ignored: no access and no `pix_rvalid`.
- `wr_ready = !(pix_req && busy)`. This is combinational; the display is never stalled.
- An accepted write drives `mem_addr = wr_addr`, `mem_we = 1`, `mem_wdata = wr_data`. Writes are legal in every state and to any address, including the buffer being displayed.
- When the memory port is idle, `mem_we = 0` and `mem_addr` holds its previous value.
- A `pix_req` in the same cycle as the terminating `frame_end` uses the old pass base and WORDS.

## Timing
- Reset values: state IDLE, counter 0. `mode`, `busy`, `done640`, `done`, `mem_we`, `pix_rvalid` and `pix_black` are 0. `mem_addr` and `mem_wdata` are 0.
- Fetch: `pix_req` at cycle N produces `mem_addr` at N+1. The RAM returns data at N+2, and `pix_rvalid` (with `pix_black`) is asserted at N+2. Back-to-back requests give one `pix_rvalid` per cycle.
- Write: acceptance at N produces `mem_we = 1` with `mem_addr` and `mem_wdata` at N+1, for exactly one cycle per accepted word.
- State, `mode`, `busy`, `done640` and `done` update at the edge after the qualifying `frame_end` or `start`.
- `rst` has priority over everything, including mid-pass. It squashes in-flight `pix_rvalid` and `mem_we` on the next edge.

## Test plan
- **Reset and sequence:** `rst`, then `start`, then 1 `frame_end`, then 1 `frame_end`.
  - `busy` is 1 one cycle after `start`.
  - `done640 = 1`, `mode = 1` after the first pulse.
  - `done = 1`, `busy = 0` after the second.
- **Fetch address:** in PASS320, `pix_req` with `pix_addr = 5`.
  - `mem_addr = 307205`, `mem_we = 0` at N+1.
  - `pix_rvalid = 1`, `pix_black = 0` at N+2.
- **Contention:** `wr_valid = 1` held while `pix_req` toggles 1,1,0,1.
  - `wr_ready` is 0,0,1,0.
  - Exactly one write occurs: `mem_we = 1` in the cycle after the third.
- **Out-of-range fetch:** `pix_addr = 307200` in PASS640.
  - `mem_addr` does not change.
  - `pix_rvalid = 1`, `pix_black = 1` at N+2.
- **Ignored controls:** `start` during PASS640 has no effect, and the counter is unchanged. `frame_end` in IDLE does not leave IDLE.
- **Reset mid-pass:** `rst` at the same cycle as `pix_req` and the final `frame_end`.
  - Next cycle: IDLE, all outputs 0.
  - No `pix_rvalid` follows.
